// File: rtl/alu_iter_sequencer_pkg.sv
// Shared ALU package: opcode encodings plus the sequencer's op and state enums.
// WORD_SIZE falls back to 32 when the build does not supply it.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_XOR = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_AND = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_SLT = 4'd8;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULHU = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } seq_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    // Bit 1 of the op selects divide, bit 0 selects the high/remainder word.
    function automatic logic op_is_div(input seq_op_t op);
        return op[1];
    endfunction

    function automatic logic op_sel_hi(input seq_op_t op);
        return op[0];
    endfunction

endpackage

// File: rtl/alu_iter_sequencer_if.sv
// Request/result handshake bundle between a requester (master) and the
// multiply/divide sequencer (slave).
interface alu_iter_sequencer_if #(parameter int XLEN = `WORD_SIZE);

    // A transfer happens on a rising edge where valid && ready; the sender
    // holds payload stable while valid && !ready, ready may depend on nothing
    // but the receiver's own state.
    logic            start_valid;
    logic            start_ready;
    logic [1:0]      op;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic            result_valid;
    logic            result_ready;
    logic [XLEN-1:0] result;

    modport master (
        output start_valid, op, operand_a, operand_b, result_ready,
        input  start_ready, result_valid, result
    );

    modport slave (
        input  start_valid, op, operand_a, operand_b, result_ready,
        output start_ready, result_valid, result
    );

endinterface

// File: rtl/alu_iter_sequencer.sv
// Radix-2 unsigned MUL/MULHU/DIVU/REMU sequencer that borrows the shared ALU.
// Optional build macro ALU_SEQ_ZERO_BYPASS_EN short-circuits multiplies by zero.
module alu_iter_sequencer
    import alu_pkg::*;
#(
    parameter int XLEN = `WORD_SIZE
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_iter_sequencer_if.slave req,
    output logic              alu_req_o,
    input  logic              alu_gnt_i,
    output logic [XLEN-1:0]   alu_in1_o,
    output logic [XLEN-1:0]   alu_in2_o,
    output logic [3:0]        alu_control_o,
    input  logic [XLEN-1:0]   alu_out_i,
    output logic              busy_o,
    output seq_state_t        state_o
);

    localparam int CW = $clog2(XLEN) + 1;

    seq_state_t      state_q;
    seq_op_t         op_q;
    logic [XLEN-1:0] hi_q, lo_q, d_q;
    logic [CW-1:0]   cnt_q;
    logic            result_valid_q;
    logic [XLEN-1:0] result_q;

    logic [XLEN-1:0] hi_sh, lo_sh, hi_d, lo_d;
    logic            carry, take, is_div, run;

    assign is_div = op_is_div(op_q);
    assign run    = (state_q == ST_RUN);

    always_comb begin
        hi_sh = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
        lo_sh = {lo_q[XLEN-2:0], 1'b0};
        carry = (alu_out_i < hi_q);
        // A set msb means the shifted remainder overflowed XLEN and is surely >= d.
        take  = hi_q[XLEN-1] || !(hi_sh < d_q);
        hi_d  = hi_q;
        lo_d  = lo_q;
        if (is_div) begin
            if (take) begin
                hi_d = alu_out_i;
                lo_d = lo_sh | {{(XLEN-1){1'b0}}, 1'b1};
            end else begin
                hi_d = hi_sh;
                lo_d = lo_sh;
            end
        end else if (lo_q[0]) begin
            hi_d = {carry, alu_out_i[XLEN-1:1]};
            lo_d = {alu_out_i[0], lo_q[XLEN-1:1]};
        end else begin
            hi_d = {1'b0, hi_q[XLEN-1:1]};
            lo_d = {hi_q[0], lo_q[XLEN-1:1]};
        end
    end

    assign alu_req_o     = run;
    assign alu_in1_o     = run ? (is_div ? hi_sh : hi_q) : '0;
    assign alu_in2_o     = run ? d_q : '0;
    assign alu_control_o = (run && is_div) ? ALU_SUB : ALU_ADD;

    assign req.start_ready  = (state_q == ST_IDLE);
    assign req.result_valid = result_valid_q;
    assign req.result       = result_q;
    assign busy_o           = (state_q != ST_IDLE);
    assign state_o          = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            op_q           <= OP_MUL;
            hi_q           <= '0;
            lo_q           <= '0;
            d_q            <= '0;
            cnt_q          <= '0;
            result_valid_q <= 1'b0;
            result_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req.start_valid) begin
                        op_q    <= seq_op_t'(req.op);
                        cnt_q   <= '0;
                        hi_q    <= '0;
                        d_q     <= req.op[1] ? req.operand_b : req.operand_a;
                        lo_q    <= req.op[1] ? req.operand_a : req.operand_b;
                        state_q <= ST_RUN;
                        if (req.op[1] && (req.operand_b == '0)) begin
                            hi_q    <= req.operand_a;
                            lo_q    <= '1;
                            state_q <= ST_DONE;
                        end
`ifdef ALU_SEQ_ZERO_BYPASS_EN
                        else if (!req.op[1] &&
                                 ((req.operand_a == '0) || (req.operand_b == '0))) begin
                            lo_q    <= '0;
                            state_q <= ST_DONE;
                        end
`endif
                    end
                end
                ST_RUN: begin
                    if (alu_gnt_i) begin
                        hi_q  <= hi_d;
                        lo_q  <= lo_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(XLEN - 1)) begin
                            state_q        <= ST_DONE;
                            result_valid_q <= 1'b1;
                            result_q       <= op_sel_hi(op_q) ? hi_d : lo_d;
                        end
                    end
                end
                ST_DONE: begin
                    // Bypassed ops arrive here with result_valid still low.
                    if (!result_valid_q) begin
                        result_valid_q <= 1'b1;
                        result_q       <= op_sel_hi(op_q) ? hi_q : lo_q;
                    end else if (req.result_ready) begin
                        result_valid_q <= 1'b0;
                        result_q       <= '0;
                        state_q        <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_iter_sequencer.sv
// Self-checking bench for alu_iter_sequencer: directed vector table, corner
// sequences (stall/hold/poke, mid-run reset) and randomized ops vs a 64-bit model.
module tb_alu_iter_sequencer;
    import alu_pkg::*;

    localparam int XLEN = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             alu_req, alu_gnt;
    logic [XLEN-1:0]  alu_in1, alu_in2, alu_out;
    logic [3:0]       alu_control;
    logic             busy;
    seq_state_t       state_dbg;

    int tests = 0;
    int fails = 0;

    alu_iter_sequencer_if #(.XLEN(XLEN)) sif ();

    alu_iter_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (sif),
        .alu_req_o     (alu_req),
        .alu_gnt_i     (alu_gnt),
        .alu_in1_o     (alu_in1),
        .alu_in2_o     (alu_in2),
        .alu_control_o (alu_control),
        .alu_out_i     (alu_out),
        .busy_o        (busy),
        .state_o       (state_dbg)
    );

    always #5 clk = ~clk;

    // Shared ALU as seen by the sequencer: only ADD and SUB are exercised.
    assign alu_out = (alu_control == 4'd1) ? (alu_in1 - alu_in2) : (alu_in1 + alu_in2);

    typedef struct {
        logic [1:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] model(input logic [1:0] op, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (op)
            2'b00:   return p[31:0];
            2'b01:   return p[63:32];
            2'b10:   return (b == 0) ? '1 : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_bypass(input logic [1:0] op, input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
        bit r;
        r = op[1] && (b == 0);
`ifdef ALU_SEQ_ZERO_BYPASS_EN
        r = r || (!op[1] && ((a == 0) || (b == 0)));
`else
        r = r || (a != a);
`endif
        return r;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, " start_ready"}, sif.start_ready, 1);
        check({tag, " result_valid"}, sif.result_valid, 0);
        check({tag, " result"}, sif.result, 0);
        check({tag, " alu_req"}, alu_req, 0);
        check({tag, " alu_ops"}, {alu_in1, alu_in2, alu_control}, 0);
        check({tag, " busy/state"}, {busy, state_dbg}, {1'b0, ST_IDLE});
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp_res,
                          input int gnt_pct, input int hold, input bit poke);
        int k, grants, exp_lat, ctl_bad, unstable;
        bit bypass, seen_req;
        bypass   = is_bypass(op, a, b);
        exp_lat  = bypass ? 1 : -1;
        k        = 0;
        grants   = 0;
        ctl_bad  = 0;
        unstable = 0;
        seen_req = 0;
        @(negedge clk);
        check({tag, " start_ready"}, sif.start_ready, 1);
        sif.start_valid = 1'b1;
        sif.op          = op;
        sif.operand_a   = a;
        sif.operand_b   = b;
        @(posedge clk);
        #1;
        sif.start_valid = 1'b0;
        sif.operand_a   = $urandom;
        sif.operand_b   = $urandom;
        while (k < 400) begin
            @(negedge clk);
            if (sif.result_valid) break;
            if (alu_req) begin
                seen_req = 1;
                if (alu_control != {3'b000, op[1]}) ctl_bad++;
            end else if ({alu_in1, alu_in2, alu_control} != 0) begin
                ctl_bad++;
            end
            sif.start_valid = poke && (k == 5);
            sif.op          = ~op;
            alu_gnt         = ($urandom_range(99) < gnt_pct);
            @(posedge clk);
            k++;
            if (!bypass && alu_gnt && grants < XLEN) begin
                grants++;
                if (grants == XLEN) exp_lat = k;
            end
        end
        sif.start_valid = 1'b0;
        alu_gnt         = 1'b0;
        check({tag, " latency"}, k, exp_lat);
        check({tag, " result"}, sif.result, exp_res);
        check({tag, " alu_req used"}, seen_req, !bypass);
        check({tag, " alu ctl"}, ctl_bad, 0);
        if (hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if (!sif.result_valid || sif.start_ready || sif.result != exp_res) unstable++;
                sif.start_valid = poke;
                sif.operand_a   = $urandom;
            end
            check({tag, " hold stable"}, unstable, 0);
        end
        @(negedge clk);
        sif.start_valid  = 1'b0;
        sif.result_ready = 1'b1;
        @(posedge clk);
        #1;
        sif.result_ready = 1'b0;
        check({tag, " idle after"}, {sif.result_valid, sif.start_ready, busy}, 3'b010);
    endtask

    initial begin
        rst_n            = 1'b0;
        alu_gnt          = 1'b0;
        sif.start_valid  = 1'b0;
        sif.op           = 2'b00;
        sif.operand_a    = '0;
        sif.operand_b    = '0;
        sif.result_ready = 1'b0;

        vecs[0] = '{2'b00, 32'd7, 32'd6, 32'd42};
        vecs[1] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[2] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[3] = '{2'b10, 32'd100, 32'd7, 32'd14};
        vecs[4] = '{2'b11, 32'd100, 32'd7, 32'd2};
        vecs[5] = '{2'b10, 32'h8000_0000, 32'd1, 32'h8000_0000};
        vecs[6] = '{2'b10, 32'h1234, 32'd0, 32'hFFFF_FFFF};
        vecs[7] = '{2'b11, 32'h1234, 32'd0, 32'h1234};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("post-reset");

        for (int i = 0; i < 8; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 100, 0, 0);

        run_op("mul stall", 2'b00, 32'd7, 32'd6, 32'd42, 50, 5, 1);

        // Reset in the middle of a multiply, then a fresh divide.
        @(negedge clk);
        sif.start_valid = 1'b1;
        sif.op          = 2'b00;
        sif.operand_a   = 32'd7;
        sif.operand_b   = 32'd6;
        alu_gnt         = 1'b1;
        @(posedge clk);
        #1 sif.start_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrun reset");
        alu_gnt = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op("div after reset", 2'b10, 32'd9, 32'd3, 32'd3, 100, 0, 0);

        for (int i = 0; i < 24; i++) begin
            logic [1:0]      rop;
            logic [XLEN-1:0] ra, rb;
            rop = 2'($urandom_range(3));
            ra  = ($urandom_range(3) == 0) ? 32'd0 : $urandom;
            rb  = ($urandom_range(3) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(1) == 1) rb = rb >> $urandom_range(31);
            run_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, model(rop, ra, rb),
                   $urandom_range(100, 30), $urandom_range(3), 1'($urandom_range(1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
